// File: rtl/ctrl_pkg.sv
// Shared MIPS opcode/funct constants, ALU op codes and the decoded-entry layout
// used by the control/decode stage and its combinational decoder.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_LHU    = 6'h25;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   localparam int ALU_W = 5;

   localparam logic [ALU_W-1:0] ALU_NOP  = 5'd0;
   localparam logic [ALU_W-1:0] ALU_ADD  = 5'd1;
   localparam logic [ALU_W-1:0] ALU_SUB  = 5'd2;
   localparam logic [ALU_W-1:0] ALU_AND  = 5'd3;
   localparam logic [ALU_W-1:0] ALU_OR   = 5'd4;
   localparam logic [ALU_W-1:0] ALU_XOR  = 5'd5;
   localparam logic [ALU_W-1:0] ALU_NOR  = 5'd6;
   localparam logic [ALU_W-1:0] ALU_SLT  = 5'd7;
   localparam logic [ALU_W-1:0] ALU_SLTU = 5'd8;
   localparam logic [ALU_W-1:0] ALU_SLL  = 5'd9;
   localparam logic [ALU_W-1:0] ALU_SRL  = 5'd10;
   localparam logic [ALU_W-1:0] ALU_SRA  = 5'd11;
   localparam logic [ALU_W-1:0] ALU_LUI  = 5'd12;

   typedef struct packed {
      logic [ALU_W-1:0] alu_op;
      logic             i_or_r;
      logic             reg_write;
      logic             load;
      logic             bus_write;
      logic             branch;
      logic             jump;
      logic             jump_reg;
      logic             illegal;
      logic [4:0]       rs;
      logic [4:0]       rt;
      logic [4:0]       rd;
      logic [31:0]      imm;
   } entry_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational MIPS instruction -> decoded entry.
// CTRL_ILLEGAL_EN: flag unsupported encodings through the illegal bit.
module ctrl_decode_comb
   import ctrl_pkg::*;
(
   input  logic [31:0] instr,
   output entry_t      entry
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic        rw;
   logic        legal;
   entry_t      e;

   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign funct = instr[5:0];
   assign imm16 = instr[15:0];

   always_comb begin
      e        = '0;
      rw       = 1'b0;
      legal    = 1'b1;
      e.i_or_r = (op == OP_RTYPE);
      e.rs     = rs;
      e.rt     = rt;
      e.rd     = (op == OP_RTYPE) ? rd : rt;
      e.imm    = {{16{imm16[15]}}, imm16};
      unique case (op)
         OP_RTYPE: begin
            rw = 1'b1;
            unique case (funct)
               F_ADD, F_ADDU: e.alu_op = ALU_ADD;
               F_SUB, F_SUBU: e.alu_op = ALU_SUB;
               F_AND:         e.alu_op = ALU_AND;
               F_OR:          e.alu_op = ALU_OR;
               F_XOR:         e.alu_op = ALU_XOR;
               F_NOR:         e.alu_op = ALU_NOR;
               F_SLT:         e.alu_op = ALU_SLT;
               F_SLTU:        e.alu_op = ALU_SLTU;
               F_SLL:         e.alu_op = ALU_SLL;
               F_SRL:         e.alu_op = ALU_SRL;
               F_SRA:         e.alu_op = ALU_SRA;
               F_JR: begin
                  rw         = 1'b0;
                  e.jump_reg = 1'b1;
               end
               default: begin
                  rw    = 1'b0;
                  legal = 1'b0;
               end
            endcase
         end
         OP_REGIMM: begin
            // only BLTZ (rt==0) is supported in the REGIMM group
            if (rt == 5'd0) begin
               e.branch = 1'b1;
               e.alu_op = ALU_SLT;
            end else begin
               legal = 1'b0;
            end
         end
         OP_J: e.jump = 1'b1;
         OP_BEQ, OP_BNE: begin
            e.branch = 1'b1;
            e.alu_op = ALU_SUB;
         end
         OP_BLEZ, OP_BGTZ: begin
            e.branch = 1'b1;
            e.alu_op = ALU_SLT;
         end
         OP_ADDI, OP_ADDIU: begin
            rw       = 1'b1;
            e.alu_op = ALU_ADD;
         end
         OP_SLTI: begin
            rw       = 1'b1;
            e.alu_op = ALU_SLT;
         end
         OP_SLTIU: begin
            rw       = 1'b1;
            e.alu_op = ALU_SLTU;
         end
         OP_ANDI: begin
            rw       = 1'b1;
            e.alu_op = ALU_AND;
            e.imm    = {16'h0000, imm16};
         end
         OP_ORI: begin
            rw       = 1'b1;
            e.alu_op = ALU_OR;
            e.imm    = {16'h0000, imm16};
         end
         OP_XORI: begin
            rw       = 1'b1;
            e.alu_op = ALU_XOR;
            e.imm    = {16'h0000, imm16};
         end
         OP_LUI: begin
            rw       = 1'b1;
            e.alu_op = ALU_LUI;
            e.imm    = {imm16, 16'h0000};
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            rw       = 1'b1;
            e.load   = 1'b1;
            e.alu_op = ALU_ADD;
         end
         OP_SW: begin
            e.bus_write = 1'b1;
            e.alu_op    = ALU_ADD;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         e.alu_op    = ALU_NOP;
         e.i_or_r    = 1'b0;
         rw          = 1'b0;
         e.load      = 1'b0;
         e.bus_write = 1'b0;
         e.branch    = 1'b0;
         e.jump      = 1'b0;
         e.jump_reg  = 1'b0;
      end
`ifdef CTRL_ILLEGAL_EN
      e.illegal = ~legal;
`endif
      // $zero is never a real write target
      e.reg_write = rw & (e.rd != 5'd0);
   end

   assign entry = e;

endmodule

// File: rtl/ctrl_decode_stage.sv
// Pipelined MIPS control/decode stage: decoded-entry buffer, load-use bubbles, flush.
// CTRL_ILLEGAL_EN enables the illegal-encoding flag in the decoder.
module ctrl_decode_stage
   import ctrl_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int ALU_OP_W   = 5,
   parameter int LU_BUBBLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         instr,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                i_or_r,
   output logic                reg_write,
   output logic                load,
   output logic                bus_write,
   output logic                branch,
   output logic                jump,
   output logic                jump_reg,
   output logic [4:0]          rs,
   output logic [4:0]          rt,
   output logic [4:0]          rd,
   output logic [31:0]         imm,
   output logic                illegal
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   entry_t        dec;
   entry_t        head;
   entry_t        mem [DEPTH];
   logic [PW-1:0] head_ptr;
   logic [PW-1:0] tail_ptr;
   logic [CW-1:0] count;
   logic          hazard;
   logic          stall;
   logic          push;
   logic          pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   ctrl_decode_comb u_dec (
      .instr (instr),
      .entry (dec)
   );

   assign in_ready  = (count < CW'(DEPTH)) & ~stall & ~hazard & ~flush;
   assign push      = in_valid & in_ready;
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign head      = out_valid ? mem[head_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         if (push) begin
            mem[tail_ptr] <= dec;
            tail_ptr      <= nxt(tail_ptr);
         end
         if (pop) head_ptr <= nxt(head_ptr);
         if (push & ~pop) count <= count + 1'b1;
         else if (pop & ~push) count <= count - 1'b1;
      end
   end

   generate
      if (LU_BUBBLES > 0) begin : g_lu
         logic       trk_valid;
         logic [4:0] trk_reg;
         logic [1:0] bubble;
         logic       uses;

         assign uses = (dec.rs == trk_reg)
                     | ((dec.rt == trk_reg)
                        & ((instr[31:26] == OP_RTYPE)
                           | dec.bus_write | dec.branch));
         assign hazard = trk_valid & in_valid & uses;
         assign stall  = (bubble != 2'd0);

         // the hazard cycle itself is the first bubble; the rest count down
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               trk_valid <= 1'b0;
               trk_reg   <= '0;
               bubble    <= '0;
            end else if (flush) begin
               trk_valid <= 1'b0;
               bubble    <= '0;
            end else if (hazard) begin
               trk_valid <= 1'b0;
               bubble    <= 2'(LU_BUBBLES - 1);
            end else begin
               if (bubble != 2'd0) bubble <= bubble - 1'b1;
               if (push) begin
                  trk_valid <= dec.load & (dec.rt != 5'd0);
                  trk_reg   <= dec.rt;
               end
            end
         end
      end else begin : g_nolu
         assign hazard = 1'b0;
         assign stall  = 1'b0;
      end
   endgenerate

   assign alu_op    = ALU_OP_W'(head.alu_op);
   assign i_or_r    = head.i_or_r;
   assign reg_write = head.reg_write;
   assign load      = head.load;
   assign bus_write = head.bus_write;
   assign branch    = head.branch;
   assign jump      = head.jump;
   assign jump_reg  = head.jump_reg;
   assign rs        = head.rs;
   assign rt        = head.rt;
   assign rd        = head.rd;
   assign imm       = head.imm;
   assign illegal   = head.illegal;

endmodule
